// File: rtl/gate_share_arbiter.sv
// gate_share_arbiter: round-robin arbiter sharing one registered and2 slot among NREQ requesters.
// Optional GATE_ARB_LOCK_EN adds a lock input that re-grants the last winner for up to 4 grants.
module gate_share_arbiter #(
  parameter int NREQ = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           a,
  input  logic [NREQ-1:0]           b,
  output logic [NREQ-1:0]           gnt,
  output logic                      c,
  output logic                      c_valid,
  output logic [$clog2(NREQ)-1:0]   c_id,
  output logic                      busy
`ifdef GATE_ARB_LOCK_EN
  ,input logic [NREQ-1:0]           lock
`endif
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, GRANT, EVAL} state_t;
  state_t state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d, cand;
  logic c_q, c_d, c_valid_q, c_valid_d, hold, found, is_g;
  logic [IW-1:0] c_id_q, c_id_d, last_q, last_d, win;
`ifdef GATE_ARB_LOCK_EN
  logic [2:0] streak_q, streak_d;
  assign hold = state_q == EVAL && lock[last_q] && req[last_q] && streak_q < 3'd4;
  assign streak_d = !is_g && found ? (hold ? streak_q + 3'd1 : 3'd1) : streak_q;
  always_ff @(posedge clk)
    if (rst) streak_q <= '0;
    else streak_q <= streak_d;
`else
  assign hold = 1'b0;
`endif
  assign is_g = state_q == GRANT;
  // the owner of the result just produced is excluded from the next search
  assign cand = state_q == EVAL ? req & ~(NREQ'(1) << last_q) : req;
  always_comb begin
    found = 1'b0;
    win = last_q;
    for (int i = 1; i <= NREQ; i++)
      if (!found && cand[(int'(last_q) + i) % NREQ]) begin
        found = 1'b1;
        win = IW'((int'(last_q) + i) % NREQ);
      end
    if (hold) begin
      found = 1'b1;
      win = last_q;
    end
  end
  always_comb begin
    state_d = is_g ? EVAL : found ? GRANT : IDLE;
    gnt_d = !is_g && found ? NREQ'(1) << win : '0;
    last_d = !is_g && found ? win : last_q;
    c_d = is_g & a[last_q] & b[last_q];
    c_valid_d = is_g;
    c_id_d = is_g ? last_q : '0;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      gnt_q <= '0;
      c_q <= 1'b0;
      c_valid_q <= 1'b0;
      c_id_q <= '0;
      last_q <= IW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      c_q <= c_d;
      c_valid_q <= c_valid_d;
      c_id_q <= c_id_d;
      last_q <= last_d;
    end
  assign gnt = gnt_q;
  assign c = c_q;
  assign c_valid = c_valid_q;
  assign c_id = c_id_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_gate_share_arbiter.sv
// tb_gate_share_arbiter: directed vector table, id-sequence checks and randomized model comparison.
module tb_gate_share_arbiter;
  localparam int NREQ = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0] req = '0, a = '0, b = '0, gnt;
  logic c, c_valid, busy;
  logic [1:0] c_id;
`ifdef GATE_ARB_LOCK_EN
  logic [NREQ-1:0] lock = '0;
`endif
  int errors = 0, checks = 0;
  gate_share_arbiter #(.NREQ(NREQ)) dut (
    .clk(clk), .rst(rst), .req(req), .a(a), .b(b), .gnt(gnt),
    .c(c), .c_valid(c_valid), .c_id(c_id), .busy(busy)
`ifdef GATE_ARB_LOCK_EN
    , .lock(lock)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic rst;
    logic [3:0] req, a, b, gnt;
    logic c, cv;
    logic [1:0] id;
    logic busy;
  } vec_t;
  vec_t vecs[$];
  int ph = 0, m_last = NREQ - 1, m_run = 0, e_id = 0;
  logic [NREQ-1:0] e_gnt = '0;
  logic e_c = 0, e_cv = 0, e_busy = 0;
  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, act, exp);
    end
  endfunction
  // transaction view: phase 0 idle, 1 operands owned by m_last, 2 result showing
  task automatic model_step();
    logic [NREQ-1:0] pool;
    bit lk;
    int w;
    e_gnt = '0; e_c = 0; e_cv = 0; e_id = 0;
    if (rst) begin
      ph = 0; m_last = NREQ - 1; m_run = 0;
    end else if (ph == 1) begin
      e_c = a[m_last] & b[m_last]; e_cv = 1; e_id = m_last; ph = 2;
    end else begin
      pool = req;
      if (ph == 2) pool[m_last] = 1'b0;
      lk = 0;
`ifdef GATE_ARB_LOCK_EN
      lk = ph == 2 && lock[m_last] && req[m_last] && m_run < 4;
`endif
      w = lk ? m_last : -1;
      for (int k = 1; k <= NREQ; k++)
        if (w < 0 && pool[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
      if (w >= 0) begin
        m_run = lk ? m_run + 1 : 1; m_last = w; e_gnt[w] = 1'b1; ph = 1;
      end else ph = 0;
    end
    e_busy = ph != 0;
  endtask
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask
  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] aa, input logic [3:0] bb,
                     input logic [3:0] g, input logic cc, input logic cv, input logic [1:0] id, input logic bs);
    vec_t v;
    v.rst = r; v.req = rq; v.a = aa; v.b = bb; v.gnt = g; v.c = cc; v.cv = cv; v.id = id; v.busy = bs;
    vecs.push_back(v);
  endtask
  task automatic id_seq(input int n_exp, input logic [2:0] e0, input logic [2:0] e1, input logic [2:0] e2,
                        input logic [2:0] e3, input logic [2:0] e4, input logic [2:0] e5);
    logic [2:0] ex [6];
    int n = 0;
    ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3; ex[4] = e4; ex[5] = e5;
    rst = 1; req = '0; step();
    rst = 0; req = 4'b0011; a = '1; b = '1;
    for (int cyc = 0; cyc < 40 && n < n_exp; cyc++) begin
      step();
      if (c_valid === 1'b1) begin
        chk("seq_id", 32'(c_id), 32'(ex[n]));
        n++;
      end
    end
    chk("seq_count", n, n_exp);
    req = '0;
  endtask
  initial begin
    add(1, 4'h0, 4'hF, 4'hF, 4'h0, 0, 0, 0, 0);
    add(0, 4'h1, 4'hF, 4'hF, 4'h1, 0, 0, 0, 1);
    add(0, 4'h0, 4'hF, 4'hF, 4'h0, 1, 1, 0, 1);
    add(0, 4'h0, 4'hF, 4'hF, 4'h0, 0, 0, 0, 0);
    add(1, 4'hF, 4'hF, 4'h7, 4'h0, 0, 0, 0, 0);
    add(0, 4'hF, 4'hF, 4'h7, 4'h1, 0, 0, 0, 1);
    add(0, 4'hF, 4'hF, 4'h7, 4'h0, 1, 1, 0, 1);
    add(0, 4'hF, 4'hF, 4'h7, 4'h2, 0, 0, 0, 1);
    add(0, 4'hF, 4'hF, 4'h7, 4'h0, 1, 1, 1, 1);
    add(0, 4'hF, 4'hF, 4'h7, 4'h4, 0, 0, 0, 1);
    add(0, 4'hF, 4'hF, 4'h7, 4'h0, 1, 1, 2, 1);
    add(0, 4'hF, 4'hF, 4'h7, 4'h8, 0, 0, 0, 1);
    add(0, 4'hF, 4'hF, 4'h7, 4'h0, 0, 1, 3, 1);
    add(0, 4'hF, 4'hF, 4'h7, 4'h1, 0, 0, 0, 1);
    add(0, 4'hF, 4'hF, 4'h7, 4'h0, 1, 1, 0, 1);
    add(0, 4'h0, 4'hF, 4'hF, 4'h0, 0, 0, 0, 0);
    add(0, 4'h1, 4'hF, 4'hF, 4'h1, 0, 0, 0, 1);
    add(0, 4'h4, 4'hF, 4'hF, 4'h0, 1, 1, 0, 1);
    add(0, 4'h2, 4'hF, 4'hF, 4'h2, 0, 0, 0, 1);
    add(0, 4'h0, 4'hF, 4'hF, 4'h0, 1, 1, 1, 1);
    add(0, 4'h0, 4'hF, 4'hF, 4'h0, 0, 0, 0, 0);
    add(0, 4'h4, 4'hF, 4'hF, 4'h4, 0, 0, 0, 1);
    add(0, 4'h0, 4'hF, 4'hF, 4'h0, 1, 1, 2, 1);
    add(0, 4'h0, 4'hF, 4'hF, 4'h0, 0, 0, 0, 0);
    add(0, 4'h8, 4'hF, 4'hF, 4'h8, 0, 0, 0, 1);
    add(0, 4'h8, 4'hF, 4'hF, 4'h0, 1, 1, 3, 1);
    add(1, 4'h9, 4'hF, 4'hF, 4'h0, 0, 0, 0, 0);
    add(0, 4'h9, 4'hF, 4'hF, 4'h1, 0, 0, 0, 1);
    add(0, 4'h0, 4'hF, 4'hF, 4'h0, 1, 1, 0, 1);
    add(0, 4'h0, 4'hF, 4'hF, 4'h0, 0, 0, 0, 0);
    add(0, 4'h2, 4'hF, 4'hF, 4'h2, 0, 0, 0, 1);
    add(1, 4'h0, 4'hF, 4'hF, 4'h0, 0, 0, 0, 0);
    add(0, 4'h0, 4'hF, 4'hF, 4'h0, 0, 0, 0, 0);
    foreach (vecs[i]) begin
      rst = vecs[i].rst; req = vecs[i].req; a = vecs[i].a; b = vecs[i].b;
      step();
      chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
      chk($sformatf("vec%0d_c", i), 32'(c), 32'(vecs[i].c));
      chk($sformatf("vec%0d_cvalid", i), 32'(c_valid), 32'(vecs[i].cv));
      chk($sformatf("vec%0d_cid", i), 32'(c_id), 32'(vecs[i].id));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
    end
`ifdef GATE_ARB_LOCK_EN
    lock = 4'b0001;
    id_seq(6, 0, 0, 0, 0, 1, 0);
    lock = '0;
`else
    id_seq(4, 0, 1, 0, 1, 0, 0);
`endif
    rst = 1; step();
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 63) == 0;
      req = NREQ'($urandom & $urandom);
      a = NREQ'($urandom);
      b = NREQ'($urandom);
`ifdef GATE_ARB_LOCK_EN
      lock = NREQ'($urandom);
`endif
      step();
      chk("rnd_gnt", 32'(gnt), 32'(e_gnt));
      chk("rnd_c", 32'(c), 32'(e_c));
      chk("rnd_cvalid", 32'(c_valid), 32'(e_cv));
      chk("rnd_cid", 32'(c_id), 32'(e_id));
      chk("rnd_busy", 32'(busy), 32'(e_busy));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gate_share_arbiter.md
GATE_SHARE_ARBITER -- requirements
Module: gate_share_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of requesters sharing one and2 evaluation slot (legal range 2..8).
REQ-002 The block SHALL have port clk, input, 1, meaning the single clock; all state changes on the rising edge.
REQ-003 The block SHALL have port rst, input, 1, meaning the reset, synchronous and active-high.
REQ-004 The block SHALL have port req, input, NREQ, meaning per-requester access request, level.
REQ-005 The block SHALL have port a, input, NREQ, meaning per-requester first and2 operand.
REQ-006 The block SHALL have port b, input, NREQ, meaning per-requester second and2 operand.
REQ-007 The block SHALL have port gnt, output, NREQ, meaning one-hot grant, registered.
REQ-008 The block SHALL have port c, output, 1, meaning registered and2 result.
REQ-009 The block SHALL have port c_valid, output, 1, meaning one-cycle strobe qualifying c and c_id.
REQ-010 The block SHALL have port c_id, output, clog2(NREQ), meaning index of the requester owning c.
REQ-011 The block SHALL have port busy, output, 1, meaning high whenever state is not IDLE.

Function
REQ-012 The FSM SHALL have states IDLE, GRANT, EVAL.
REQ-013 IDLE -> GRANT when any req bit is high; gnt is set one-hot to the winner on that edge.
REQ-014 In GRANT, a[w] and b[w] of winner w SHALL be captured; GRANT -> EVAL unconditionally.
REQ-015 In EVAL, c SHALL equal captured a & b, c_valid SHALL be 1 for exactly that cycle, and c_id SHALL equal w.
REQ-016 EVAL -> GRANT if any req bit (excluding w unless the lock feature holds it) is high; otherwise EVAL -> IDLE.
REQ-017 Latency: req sampled high in IDLE at edge N -> gnt high after edge N, c_valid high after edge N+1.
REQ-018 Back-to-back throughput SHALL be one result every 2 cycles.
REQ-019 Arbitration SHALL be round-robin: search starts at index (last_winner+1) mod NREQ, wrapping past NREQ-1 to 0.
REQ-020 last_winner SHALL update only when a grant is issued.
REQ-021 gnt SHALL be high only in GRANT and never more than one bit high.
REQ-022 A requester dropping req before being granted SHALL be treated as withdrawn, with no side effect.
REQ-023 Dropping req while granted SHALL NOT abort the transaction; the captured operands still produce c_valid.
REQ-024 When all req are low, the block SHALL stay in IDLE with outputs at reset values.

Reset
REQ-025 When rst is high at an edge, state SHALL be set to IDLE and the outputs cleared: gnt=0, c=0, c_valid=0, c_id=0, busy=0.
REQ-026 Reset SHALL set last_winner to NREQ-1, so that requester 0 has first priority.
REQ-027 Reset asserted in GRANT or EVAL SHALL abandon the transaction; no c_valid is produced for it.
REQ-028 Reset SHALL take precedence over all other events in the same cycle.

Configuration
REQ-029 Macro GATE_ARB_LOCK_EN defined: the block SHALL add input lock, NREQ wide.
REQ-030 With GATE_ARB_LOCK_EN, if lock[w] and req[w] are high in EVAL, the next GRANT SHALL go to w again, bypassing rotation.
REQ-031 With GATE_ARB_LOCK_EN, the lock SHALL hold for at most 4 consecutive grants; after that, rotation SHALL be forced for one grant.
REQ-032 Macro GATE_ARB_LOCK_EN undefined: the lock port SHALL be absent and arbitration SHALL be pure round-robin.

Verification
REQ-033 Single request: after reset, req=0001, a=1, b=1 -> gnt=0001 after edge 1; c_valid=1, c=1, c_id=0 after edge 2; back to IDLE.
REQ-034 Rotation: req=1111 held with all a=b=1 -> c_id sequence 0,1,2,3,0 with c_valid every 2nd cycle.
REQ-035 Withdraw and drop: req=0100 dropped in the same cycle that req=0010 rises -> only id 1 is served. Separately, req[2] dropped during GRANT of 2 -> c_valid still fires with c_id=2.
REQ-036 Reset mid-operation: rst pulsed in EVAL -> c_valid=0 next cycle; the next request from 0 wins first.
REQ-037 Lock feature, GATE_ARB_LOCK_EN defined: req=0011 with lock=0001 -> c_id sequence 0,0,0,0,1,0.
REQ-038 Lock feature, GATE_ARB_LOCK_EN undefined: req=0011 -> c_id sequence 0,1,0,1.
